jedro_1_trap_ctrl: RTL and testbench



---
 rtl/jedro_1_defines.sv | 47 ++++
 rtl/jedro_1_irq_prio.sv | 56 +++++
 rtl/jedro_1_trap_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_jedro_1_trap_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_defines.sv
// ---------------------------------------------------------------------------
// jedro_1_defines
//   Shared definitions for the jedro_1 machine-mode trap logic:
//   - trap_state_e : trap sequencer states (IDLE/SAVE/RESTORE/JUMP)
//   - CSR_MCAUSE_* : exception and interrupt cause codes
//   - CSR_MCAUSE_INTR_BIT : position of the interrupt flag in mcause
//   - CSR_DEF_VAL_MTVEC   : mtvec value after reset
//   - intr_mcause()       : builds the mcause word for an interrupt code
// ---------------------------------------------------------------------------
package jedro_1_defines;

  localparam logic [31:0] CSR_DEF_VAL_MTVEC = 32'h0000_0000;

  // Synchronous exception codes (5-bit mcause field).
  localparam logic [4:0] CSR_MCAUSE_INSTR_ADDR_MISALIGNED = 5'd0;
  localparam logic [4:0] CSR_MCAUSE_INSTR_ACCESS_FAULT    = 5'd1;
  localparam logic [4:0] CSR_MCAUSE_ILLEGAL_INSTR         = 5'd2;
  localparam logic [4:0] CSR_MCAUSE_BREAKPOINT            = 5'd3;
  localparam logic [4:0] CSR_MCAUSE_LOAD_ADDR_MISALIGNED  = 5'd4;
  localparam logic [4:0] CSR_MCAUSE_LOAD_ACCESS_FAULT     = 5'd5;
  localparam logic [4:0] CSR_MCAUSE_STORE_ADDR_MISALIGNED = 5'd6;
  localparam logic [4:0] CSR_MCAUSE_STORE_ACCESS_FAULT    = 5'd7;
  localparam logic [4:0] CSR_MCAUSE_ECALL_M               = 5'd11;

  // Machine interrupt codes (also the mip/mie bit positions).
  localparam logic [3:0] CSR_MCAUSE_MSI = 4'd3;
  localparam logic [3:0] CSR_MCAUSE_MTI = 4'd7;
  localparam logic [3:0] CSR_MCAUSE_MEI = 4'd11;

  localparam int CSR_MCAUSE_INTR_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    JUMP    = 2'd3
  } trap_state_e;

  // mcause word for an interrupt: flag bit set, code in the low bits.
  function automatic logic [31:0] intr_mcause(input logic [3:0] code);
    logic [31:0] v;
    v = {28'b0, code};
    v[CSR_MCAUSE_INTR_BIT] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/jedro_1_irq_prio.sv
// ---------------------------------------------------------------------------
// jedro_1_irq_prio
//   Combinational machine interrupt selector. An interrupt is valid when the
//   global enable is set and at least one of MEI/MSI/MTI is both pending and
//   enabled. Priority: MEI(11) > MSI(3) > MTI(7).
//
// Ports:
//   mstatus_mie_i  in   mstatus.MIE global enable
//   mip_i          in   pending interrupts
//   mie_i          in   enabled interrupts
//   irq_valid_o    out  an interrupt may be taken
//   irq_code_o     out  code of the highest-priority interrupt (0 if none)
// ---------------------------------------------------------------------------
module jedro_1_irq_prio
  import jedro_1_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mip_i,
  input  logic [XLEN-1:0] mie_i,
  output logic            irq_valid_o,
  output logic [3:0]      irq_code_o
);

  logic w_mei;
  logic w_msi;
  logic w_mti;
  logic w_unused;

  assign w_mei = mip_i[CSR_MCAUSE_MEI] & mie_i[CSR_MCAUSE_MEI];
  assign w_msi = mip_i[CSR_MCAUSE_MSI] & mie_i[CSR_MCAUSE_MSI];
  assign w_mti = mip_i[CSR_MCAUSE_MTI] & mie_i[CSR_MCAUSE_MTI];

  // Only the three machine interrupt lines matter here.
  assign w_unused = ^{mip_i[XLEN-1:12], mip_i[10:8], mip_i[6:4], mip_i[2:0],
                      mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  always_comb begin
    irq_valid_o = 1'b0;
    irq_code_o  = 4'd0;
    if (mstatus_mie_i) begin
      if (w_mei) begin
        irq_valid_o = 1'b1;
        irq_code_o  = CSR_MCAUSE_MEI;
      end else if (w_msi) begin
        irq_valid_o = 1'b1;
        irq_code_o  = CSR_MCAUSE_MSI;
      end else if (w_mti) begin
        irq_valid_o = 1'b1;
        irq_code_o  = CSR_MCAUSE_MTI;
      end
    end
  end

endmodule

// File: rtl/jedro_1_trap_ctrl.sv
// ---------------------------------------------------------------------------
// jedro_1_trap_ctrl
//   Machine-mode trap sequencer. Takes exceptions, interrupts and MRET,
//   drives the CSR save/restore strobes, stalls the pipeline while the
//   sequence runs and finally redirects fetch to the trap vector or mepc.
//
//   Sequence: trigger in cycle N -> csr_save_o/csr_restore_o in N+1,
//   jmp_o in N+2, back in IDLE (stall_o low) in N+3.
//
//   Optional build macro JEDRO_1_TRAP_VECTORED_EN: when defined and
//   mtvec_i[1:0]==2'b01, interrupts vector to base + 4*code. Exceptions
//   always use the base. Undefined: direct mode only.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   exc_valid_i/_cause_i/_pc_i/_tval_i   synchronous exception request
//   mret_i             MRET in execute
//   instr_boundary_i   interrupts may be taken; boundary_pc_i = next PC
//   mstatus_mie_i, mip_i, mie_i, mtvec_i, mepc_i   CSR file state
//   csr_save_o + csr_mepc_o/_mcause_o/_mtval_o      trap entry strobe/data
//   csr_restore_o      MRET strobe (MIE<=MPIE, MPIE<=1)
//   stall_o            pipeline hold while not IDLE
//   jmp_o, jmp_addr_o  one-cycle fetch redirect and its target
// ---------------------------------------------------------------------------
module jedro_1_trap_ctrl
  import jedro_1_defines::*;
#(
  parameter int          XLEN       = 32,
  parameter logic [31:0] BOOT_MTVEC = CSR_DEF_VAL_MTVEC
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            exc_valid_i,
  input  logic [4:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,

  input  logic            mret_i,
  input  logic            instr_boundary_i,
  input  logic [XLEN-1:0] boundary_pc_i,

  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mip_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,

  output logic            csr_save_o,
  output logic [XLEN-1:0] csr_mepc_o,
  output logic [XLEN-1:0] csr_mcause_o,
  output logic [XLEN-1:0] csr_mtval_o,
  output logic            csr_restore_o,

  output logic            stall_o,
  output logic            jmp_o,
  output logic [XLEN-1:0] jmp_addr_o
);

  trap_state_e     r_state;
  logic            r_stall;
  logic            r_save;
  logic            r_restore;
  logic            r_jmp;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_jmp_addr;
  logic            r_is_intr;
  logic [3:0]      r_irq_code;

  logic            w_irq_valid;
  logic [3:0]      w_irq_code;
  logic            w_irq_take;
  logic [XLEN-1:0] w_mtvec_base;
  logic [XLEN-1:0] w_trap_vec;
  logic            w_unused;

  jedro_1_irq_prio #(
    .XLEN (XLEN)
  ) u_irq_prio (
    .mstatus_mie_i (mstatus_mie_i),
    .mip_i         (mip_i),
    .mie_i         (mie_i),
    .irq_valid_o   (w_irq_valid),
    .irq_code_o    (w_irq_code)
  );

  // Interrupts are only taken between instructions.
  assign w_irq_take   = w_irq_valid & instr_boundary_i;
  assign w_mtvec_base = {mtvec_i[XLEN-1:2], 2'b00};

  // Trap target, evaluated while in SAVE (mtvec_i is sampled there).
  always_comb begin
    w_trap_vec = w_mtvec_base;
`ifdef JEDRO_1_TRAP_VECTORED_EN
    if (r_is_intr && (mtvec_i[1:0] == 2'b01)) begin
      w_trap_vec = w_mtvec_base + {{(XLEN-6){1'b0}}, r_irq_code, 2'b00};
    end
`endif
  end

  // PC low bits are always forced to zero; in direct mode the mtvec mode
  // field and the interrupt bookkeeping do not influence the target.
`ifdef JEDRO_1_TRAP_VECTORED_EN
  assign w_unused = ^{exc_pc_i[1:0], boundary_pc_i[1:0], mepc_i[1:0], BOOT_MTVEC};
`else
  assign w_unused = ^{exc_pc_i[1:0], boundary_pc_i[1:0], mepc_i[1:0], BOOT_MTVEC,
                      mtvec_i[1:0], r_is_intr, r_irq_code};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_stall    <= 1'b0;
      r_save     <= 1'b0;
      r_restore  <= 1'b0;
      r_jmp      <= 1'b0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_jmp_addr <= '0;
      r_is_intr  <= 1'b0;
      r_irq_code <= 4'd0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_save    <= 1'b0;
      r_restore <= 1'b0;
      r_jmp     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (exc_valid_i) begin
            r_mepc     <= {exc_pc_i[XLEN-1:2], 2'b00};
            r_mcause   <= {{(XLEN-5){1'b0}}, exc_cause_i};
            r_mtval    <= exc_tval_i;
            r_is_intr  <= 1'b0;
            r_irq_code <= 4'd0;
            r_save     <= 1'b1;
            r_stall    <= 1'b1;
            r_state    <= SAVE;
          end else if (w_irq_take) begin
            r_mepc     <= {boundary_pc_i[XLEN-1:2], 2'b00};
            r_mcause   <= intr_mcause(w_irq_code);
            r_mtval    <= '0;
            r_is_intr  <= 1'b1;
            r_irq_code <= w_irq_code;
            r_save     <= 1'b1;
            r_stall    <= 1'b1;
            r_state    <= SAVE;
          end else if (mret_i) begin
            r_restore  <= 1'b1;
            r_stall    <= 1'b1;
            r_state    <= RESTORE;
          end
        end
        SAVE: begin
          r_jmp      <= 1'b1;
          r_jmp_addr <= w_trap_vec;
          r_state    <= JUMP;
        end
        RESTORE: begin
          r_jmp      <= 1'b1;
          r_jmp_addr <= {mepc_i[XLEN-1:2], 2'b00};
          r_state    <= JUMP;
        end
        JUMP: begin
          r_stall <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_stall <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign csr_save_o    = r_save;
  assign csr_mepc_o    = r_mepc;
  assign csr_mcause_o  = r_mcause;
  assign csr_mtval_o   = r_mtval;
  assign csr_restore_o = r_restore;
  assign stall_o       = r_stall;
  assign jmp_o         = r_jmp;
  assign jmp_addr_o    = r_jmp_addr;

endmodule

// File: tb/tb_jedro_1_trap_ctrl.sv
module tb_jedro_1_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret, boundary;
  logic [31:0] boundary_pc;
  logic        mstatus_mie;
  logic [31:0] mip, mie, mtvec, mepc;

  logic        csr_save, csr_restore, stall, jmp;
  logic [31:0] csr_mepc, csr_mcause, csr_mtval, jmp_addr;

  always #5 clk = ~clk;

  jedro_1_trap_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .exc_valid_i      (exc_valid),
    .exc_cause_i      (exc_cause),
    .exc_pc_i         (exc_pc),
    .exc_tval_i       (exc_tval),
    .mret_i           (mret),
    .instr_boundary_i (boundary),
    .boundary_pc_i    (boundary_pc),
    .mstatus_mie_i    (mstatus_mie),
    .mip_i            (mip),
    .mie_i            (mie),
    .mtvec_i          (mtvec),
    .mepc_i           (mepc),
    .csr_save_o       (csr_save),
    .csr_mepc_o       (csr_mepc),
    .csr_mcause_o     (csr_mcause),
    .csr_mtval_o      (csr_mtval),
    .csr_restore_o    (csr_restore),
    .stall_o          (stall),
    .jmp_o            (jmp),
    .jmp_addr_o       (jmp_addr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // m_step counts cycles since a trigger was accepted: 0 = idle,
  // 1 = CSR strobe cycle, 2 = redirect cycle.
  int          m_step    = 0;
  bit          m_restore = 0;
  bit          m_intr    = 0;
  int          m_code    = 0;
  logic [31:0] m_mepc    = '0;
  logic [31:0] m_mcause  = '0;
  logic [31:0] m_mtval   = '0;
  logic [31:0] m_jaddr   = '0;

  function automatic int irq_pick(input bit g, input logic [31:0] p, input logic [31:0] e);
    int order[3];
    order = '{11, 3, 7};
    if (!g) return -1;
    for (int k = 0; k < 3; k++) if (p[order[k]] && e[order[k]]) return order[k];
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_step = 0; m_restore = 0; m_intr = 0; m_code = 0;
      m_mepc = '0; m_mcause = '0; m_mtval = '0; m_jaddr = '0;
    end else if (m_step == 0) begin
      int c;
      c = irq_pick(mstatus_mie, mip, mie);
      if (exc_valid) begin
        m_step = 1; m_restore = 0; m_intr = 0; m_code = 0;
        m_mepc = exc_pc & ~32'h3;
        m_mcause = 32'(exc_cause);
        m_mtval = exc_tval;
      end else if (boundary && c >= 0) begin
        m_step = 1; m_restore = 0; m_intr = 1; m_code = c;
        m_mepc = boundary_pc & ~32'h3;
        m_mcause = 32'h8000_0000 + 32'(c);
        m_mtval = '0;
      end else if (mret) begin
        m_step = 1; m_restore = 1;
      end
    end else if (m_step == 1) begin
      if (m_restore) m_jaddr = mepc & ~32'h3;
      else begin
        m_jaddr = mtvec & ~32'h3;
`ifdef JEDRO_1_TRAP_VECTORED_EN
        if (m_intr && (mtvec & 32'h3) == 32'h1) m_jaddr = m_jaddr + 32'(4 * m_code);
`endif
      end
      m_step = 2;
    end else begin
      m_step = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("stall",    {31'b0, stall},       {31'b0, m_step != 0});
    chk("save",     {31'b0, csr_save},    {31'b0, m_step == 1 && !m_restore});
    chk("restore",  {31'b0, csr_restore}, {31'b0, m_step == 1 && m_restore});
    chk("jmp",      {31'b0, jmp},         {31'b0, m_step == 2});
    chk("jmp_addr", jmp_addr, m_jaddr);
    if (m_step == 1 && !m_restore) begin
      chk("mepc",   csr_mepc,   m_mepc);
      chk("mcause", csr_mcause, m_mcause);
      chk("mtval",  csr_mtval,  m_mtval);
    end
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    exc_valid = 0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret = 0; boundary = 0; boundary_pc = '0;
    mstatus_mie = 0; mip = '0; mie = '0;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    mtvec = 32'h0040_0000;
    mepc  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_stall",  {31'b0, stall}, 32'd0);
    chk("rst_jaddr",  jmp_addr, 32'd0);
    chk("rst_mcause", csr_mcause, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1. illegal instruction
    exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h8000_0010; exc_tval = 32'hFFFF_FFFF;
    @(negedge clk); quiet();
    chk("t1_save",   {31'b0, csr_save}, 32'd1);
    chk("t1_mepc",   csr_mepc,   32'h8000_0010);
    chk("t1_mcause", csr_mcause, 32'd2);
    chk("t1_mtval",  csr_mtval,  32'hFFFF_FFFF);
    @(negedge clk);
    chk("t1_jmp",   {31'b0, jmp}, 32'd1);
    chk("t1_jaddr", jmp_addr, 32'h0040_0000);
    @(negedge clk);
    chk("t1_idle",  {31'b0, stall}, 32'd0);

    // 2. timer interrupt
    mstatus_mie = 1; mip = 32'h80; mie = 32'h80; boundary = 1; boundary_pc = 32'h8000_0104;
    @(negedge clk); quiet();
    chk("t2_mcause", csr_mcause, 32'h8000_0007);
    chk("t2_mtval",  csr_mtval,  32'h0);
    chk("t2_mepc",   csr_mepc,   32'h8000_0104);
    @(negedge clk);
    chk("t2_jaddr",  jmp_addr, 32'h0040_0000);
    @(negedge clk);

    // 3. ECALL together with pending MEI
    mstatus_mie = 1; mip = 32'h800; mie = 32'h800; boundary = 1; boundary_pc = 32'h8000_0300;
    exc_valid = 1; exc_cause = 5'd11; exc_pc = 32'h8000_0200; exc_tval = 32'h0;
    @(negedge clk);
    exc_valid = 0; boundary = 0;
    chk("t3_mcause_exc", csr_mcause, 32'd11);
    @(negedge clk);
    chk("t3_jmp", {31'b0, jmp}, 32'd1);
    @(negedge clk);
    boundary = 1;
    @(negedge clk); quiet();
    chk("t3_save2",   {31'b0, csr_save}, 32'd1);
    chk("t3_mcause2", csr_mcause, 32'h8000_000B);
    chk("t3_mepc2",   csr_mepc,   32'h8000_0300);
    repeat (2) @(negedge clk);

    // 4. MRET
    mepc = 32'h8000_0203; mret = 1;
    @(negedge clk); quiet();
    chk("t4_restore", {31'b0, csr_restore}, 32'd1);
    chk("t4_nosave",  {31'b0, csr_save}, 32'd0);
    @(negedge clk);
    chk("t4_jmp",   {31'b0, jmp}, 32'd1);
    chk("t4_jaddr", jmp_addr, 32'h8000_0200);
    @(negedge clk);

    // 5. reset during SAVE
    exc_valid = 1; exc_cause = 5'd5; exc_pc = 32'h1234_5678; exc_tval = 32'hDEAD_BEEF;
    @(negedge clk); quiet();
    chk("t5_in_save", {31'b0, csr_save}, 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_save",   {31'b0, csr_save}, 32'd0);
    chk("t5_stall",  {31'b0, stall}, 32'd0);
    chk("t5_mcause", csr_mcause, 32'd0);
    chk("t5_jaddr",  jmp_addr, 32'd0);
    @(negedge clk);
    chk("t5_nojmp",  {31'b0, jmp}, 32'd0);

    // 6. MSI with mtvec mode field 01
    mtvec = 32'h0040_0001;
    mstatus_mie = 1; mip = 32'h8; mie = 32'h8; boundary = 1; boundary_pc = 32'h8000_0400;
    @(negedge clk); quiet();
    chk("t6_mcause", csr_mcause, 32'h8000_0003);
    @(negedge clk);
`ifdef JEDRO_1_TRAP_VECTORED_EN
    chk("t6_vec_jaddr", jmp_addr, 32'h0040_000C);
`else
    chk("t6_dir_jaddr", jmp_addr, 32'h0040_0000);
`endif
    @(negedge clk);
    exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h8000_0500;
    @(negedge clk); quiet();
    @(negedge clk);
    chk("t6_exc_jaddr", jmp_addr, 32'h0040_0000);
    @(negedge clk);

    // randomized traffic, checked by the compare process against the model
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      exc_valid   = ($urandom_range(0, 7) == 0);
      exc_cause   = 5'($urandom_range(0, 11));
      exc_pc      = $urandom;
      exc_tval    = $urandom;
      mret        = ($urandom_range(0, 5) == 0);
      boundary    = $urandom_range(0, 1) == 1;
      boundary_pc = $urandom;
      mstatus_mie = $urandom_range(0, 1) == 1;
      mip         = ($urandom & 32'h0000_0888) | ($urandom & 32'hFFFF_F000);
      mie         = ($urandom & 32'h0000_0888) | ($urandom & 32'h0000_0777);
      mtvec       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | 32'($urandom_range(0, 3));
      mepc        = $urandom;
      @(negedge clk);
    end
    rst = 0;
    quiet();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
